icache_line_refill: RTL and testbench

Direct-mapped instruction cache with a line-refill state machine for the pipelined OTTER MCU. It sits between the fetch stage (PC-addressed reads) and the slow instruction memory. It serves hits combinationally and reads whole lines from memory on a miss, one word per handshake. It is the memory-reading end of the instruction-memory interface: it issues requests and the memory answers.

---
 rtl/icache_line_refill_if.sv | 27 ++
 rtl/icache_line_refill.sv | 132 +++++++++++++
 tb/tb_icache_line_refill.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_line_refill_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Latency: none; this is wiring only.
// Backpressure: cpu_stall holds the fetch stage; mem_ack paces the refill reads.
interface icache_line_refill_if;
  logic [31:0] cpu_addr;
  logic        cpu_rd;
  logic        flush;
  logic [31:0] cpu_instr;
  logic        cpu_hit;
  logic        cpu_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // The cache answers the fetch stage and issues requests to memory.
  modport master (
    input  cpu_addr, cpu_rd, flush, mem_rdata, mem_ack,
    output cpu_instr, cpu_hit, cpu_stall, mem_req, mem_addr
  );

  // The fetch stage and the instruction memory, seen from outside the cache.
  modport slave (
    output cpu_addr, cpu_rd, flush, mem_rdata, mem_ack,
    input  cpu_instr, cpu_hit, cpu_stall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_line_refill.sv
// Direct-mapped instruction cache; a miss refills the whole line one word per mem_ack.
// Latency: hits are combinational; a miss with an ack every cycle stalls for WORDS+2 cycles.
// Backpressure: cpu_stall holds fetch; the fill waits on mem_ack indefinitely. ICACHE_STATS_EN adds hit/miss counters.
module icache_line_refill #(
  parameter int LINES = 16,
  parameter int WORDS = 8
) (
  input logic                   clk,
  input logic                   clr,
  icache_line_refill_if.master  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int LSB   = OFF_W + 2;
  localparam int TAG_W = 32 - LSB - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t             state_q;
  logic [OFF_W-1:0]   wcnt_q;
  logic [IDX_W-1:0]   fill_idx_q;
  logic [TAG_W-1:0]   fill_tag_q;
  logic               mem_req_q;
  logic [31:0]        mem_addr_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES*WORDS];

  logic [OFF_W-1:0]   cpu_off;
  logic [IDX_W-1:0]   cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic               lookup_hit;
  logic               miss_start;
  logic               ack_take;
  logic               unused_addr_bits;

  assign cpu_off    = bus.cpu_addr[LSB-1:2];
  assign cpu_idx    = bus.cpu_addr[LSB +: IDX_W];
  assign cpu_tag    = bus.cpu_addr[31 -: TAG_W];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  assign lookup_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  // Flush has priority over starting a fill in the same cycle.
  assign miss_start = (state_q == S_IDLE) && bus.cpu_rd && !lookup_hit && !bus.flush;
  // Acks only count while a request is actually outstanding.
  assign ack_take   = (state_q == S_FILL) && mem_req_q && bus.mem_ack;

  assign bus.cpu_hit   = lookup_hit && (state_q == S_IDLE);
  assign bus.cpu_stall = (bus.cpu_rd && !bus.cpu_hit) || (state_q != S_IDLE);
  assign bus.cpu_instr = data_q[{cpu_idx, cpu_off}];
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;

  // Refill FSM: latches the miss line, walks its words, then validates it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
    end else if (bus.flush) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      mem_req_q <= 1'b0;
      valid_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss_start) begin
            fill_idx_q       <= cpu_idx;
            fill_tag_q       <= cpu_tag;
            mem_addr_q       <= {bus.cpu_addr[31:LSB], {LSB{1'b0}}};
            mem_req_q        <= 1'b1;
            wcnt_q           <= '0;
            valid_q[cpu_idx] <= 1'b0;
            state_q          <= S_FILL;
          end
        end
        S_FILL: begin
          if (ack_take) begin
            wcnt_q     <= wcnt_q + 1'b1;
            mem_addr_q <= mem_addr_q + 32'd4;
            if (wcnt_q == OFF_W'(WORDS - 1)) begin
              mem_req_q <= 1'b0;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          valid_q[fill_idx_q] <= 1'b1;
          state_q             <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line storage: words land as they are acked, the tag is written as the line completes.
  always_ff @(posedge clk) begin
    if (ack_take) begin
      data_q[{fill_idx_q, wcnt_q}] <= bus.mem_rdata;
    end
    if (state_q == S_DONE) begin
      tag_q[fill_idx_q] <= fill_tag_q;
    end
  end

`ifdef ICACHE_STATS_EN
  // Performance counters: hits per serviced fetch cycle, misses per fill started.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (bus.cpu_rd && bus.cpu_hit) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_start) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_icache_line_refill.sv
// Directed bench for icache_line_refill with a memory responder of configurable ack spacing.
// Memory word at byte address A reads back as 0x1000_0000 + A.
// Outputs are sampled 2 time units after the rising edge; memory drives on the falling edge.
module tb_icache_line_refill;
  logic clk;
  logic clr;

  icache_line_refill_if bus();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_line_refill dut (
    .clk        (clk),
    .clr        (clr),
    .bus        (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int checks = 0;
  int failures = 0;
  int period = 1;
  int acks_given = 0;
  bit stray = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic apply(input logic [31:0] addr, input logic rd);
    bus.cpu_addr = addr;
    bus.cpu_rd   = rd;
    #1;
  endtask

  // Counts stall cycles from the current one and checks every outstanding request address.
  task automatic wait_fill(input logic [31:0] base, input int exp_stall, input string tag);
    int n;
    int guard;
    n = 0;
    guard = 0;
    acks_given = 0;
    while (bus.cpu_stall === 1'b1 && guard < 400) begin
      n++;
      guard++;
      cyc();
      if (bus.mem_req === 1'b1)
        chk({tag, "_addr"}, bus.mem_addr, base + 32'(4 * acks_given));
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
  endtask

  // Instruction memory: acks every 'period' cycles while a request is up.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_rdata = 32'h1000_0000 + bus.mem_addr;
      if (bus.mem_req === 1'b1) begin
        if (cnt == period - 1) begin
          bus.mem_ack = 1'b1;
          cnt = 0;
          acks_given++;
        end else begin
          bus.mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        cnt = 0;
        bus.mem_ack = stray;
      end
    end
  end

  initial begin
    int g;
    clr = 1'b1;
    bus.cpu_addr = '0;
    bus.cpu_rd = 1'b0;
    bus.flush = 1'b0;

    // Reset state
    #12;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_hit", 32'(bus.cpu_hit), 32'd0);
    chk("rst_stall_rd0", 32'(bus.cpu_stall), 32'd0);
    apply(32'h40, 1'b1);
    chk("rst_stall_rd1", 32'(bus.cpu_stall), 32'd1);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    apply(32'h0, 1'b0);
    cyc();
    clr = 1'b0;
    cyc();

    // Cold miss on 0x40
    apply(32'h40, 1'b1);
    chk("cold_hit0", 32'(bus.cpu_hit), 32'd0);
    wait_fill(32'h40, 10, "cold");
    chk("cold_hit", 32'(bus.cpu_hit), 32'd1);
    chk("cold_instr", bus.cpu_instr, 32'h1000_0040);
    chk("cold_req_low", 32'(bus.mem_req), 32'd0);

    // Hits inside the filled line
    apply(32'h48, 1'b1);
    chk("hit48_hit", 32'(bus.cpu_hit), 32'd1);
    chk("hit48_instr", bus.cpu_instr, 32'h1000_0048);
    chk("hit48_stall", 32'(bus.cpu_stall), 32'd0);
    apply(32'h5C, 1'b1);
    chk("hit5c_instr", bus.cpu_instr, 32'h1000_005C);
    cyc();
    chk("hit_no_req", 32'(bus.mem_req), 32'd0);

    // Conflict: 0x240 shares the index of 0x40
    apply(32'h240, 1'b1);
    chk("conf_miss", 32'(bus.cpu_hit), 32'd0);
    wait_fill(32'h240, 10, "conf");
    chk("conf_instr", bus.cpu_instr, 32'h1000_0240);
    apply(32'h40, 1'b1);
    chk("conf_reread_miss", 32'(bus.cpu_hit), 32'd0);
    wait_fill(32'h40, 10, "refill40");
    chk("refill40_instr", bus.cpu_instr, 32'h1000_0040);

    // Slow memory: one ack every third cycle
    period = 3;
    apply(32'h80, 1'b1);
    wait_fill(32'h80, 26, "slow");
    chk("slow_instr80", bus.cpu_instr, 32'h1000_0080);
    apply(32'h9C, 1'b1);
    chk("slow_instr9c", bus.cpu_instr, 32'h1000_009C);
    period = 1;

    // Flush together with a miss: no fill starts, everything invalidated
    bus.flush = 1'b1;
    apply(32'h100, 1'b1);
    cyc();
    chk("flushmiss_req", 32'(bus.mem_req), 32'd0);
    bus.flush = 1'b0;
    apply(32'h40, 1'b1);
    chk("flushmiss_inval", 32'(bus.cpu_hit), 32'd0);
    apply(32'h0, 1'b0);

    // Flush after three acks of a fill
    apply(32'hC0, 1'b1);
    acks_given = 0;
    g = 0;
    while (acks_given < 3 && g < 50) begin
      cyc();
      g++;
    end
    chk("flush_acks_seen", 32'(acks_given), 32'd3);
    bus.flush = 1'b1;
    apply(32'hC0, 1'b0);
    cyc();
    chk("flush_req_drop", 32'(bus.mem_req), 32'd0);
    chk("flush_idle", 32'(bus.cpu_stall), 32'd0);
    bus.flush = 1'b0;
    stray = 1'b1;
    cyc();
    stray = 1'b0;
    chk("stray_req", 32'(bus.mem_req), 32'd0);
    chk("stray_idle", 32'(bus.cpu_stall), 32'd0);
    apply(32'h40, 1'b1);
    chk("flush_reread_miss", 32'(bus.cpu_hit), 32'd0);
    wait_fill(32'h40, 10, "restart");
    chk("restart_hit", 32'(bus.cpu_hit), 32'd1);
    chk("restart_instr", bus.cpu_instr, 32'h1000_0040);

    // Asynchronous reset in the middle of a fill
    apply(32'h300, 1'b1);
    acks_given = 0;
    g = 0;
    while (acks_given < 2 && g < 50) begin
      cyc();
      g++;
    end
    chk("rstfill_req_before", 32'(bus.mem_req), 32'd1);
    apply(32'h300, 1'b0);
    clr = 1'b1;
    #1;
    chk("rstfill_req", 32'(bus.mem_req), 32'd0);
    chk("rstfill_idle", 32'(bus.cpu_stall), 32'd0);
    clr = 1'b0;
    #1;
    apply(32'h40, 1'b1);
    chk("rstfill_inval", 32'(bus.cpu_hit), 32'd0);
    wait_fill(32'h40, 10, "postrst");
    chk("postrst_instr", bus.cpu_instr, 32'h1000_0040);
    cyc();
    apply(32'h40, 1'b0);
`ifdef ICACHE_STATS_EN
    chk("stats_hit_count", hit_count, 32'd1);
    chk("stats_miss_count", miss_count, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
